// File: rtl/riscv_alu_arbiter.sv
// riscv_alu_arbiter: shares one ALU between two requesters, one operation in flight at a time.
module riscv_alu_arbiter #(
  parameter int XLEN         = 32,
  parameter int ALU_OP_WIDTH = 7,
  parameter int PRIO_MODE    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid_i,
  output logic [1:0]              req_ready_o,
  input  logic [ALU_OP_WIDTH-1:0] req0_operator_i,
  input  logic [XLEN-1:0]         req0_operand_a_i,
  input  logic [XLEN-1:0]         req0_operand_b_i,
  input  logic [ALU_OP_WIDTH-1:0] req1_operator_i,
  input  logic [XLEN-1:0]         req1_operand_a_i,
  input  logic [XLEN-1:0]         req1_operand_b_i,
  output logic [ALU_OP_WIDTH-1:0] alu_operator_o,
  output logic [XLEN-1:0]         alu_operand_a_o,
  output logic [XLEN-1:0]         alu_operand_b_o,
  input  logic [XLEN-1:0]         alu_result_i,
  input  logic                    alu_comparison_i,
  input  logic                    alu_ready_i,
  output logic                    alu_ex_ready_o,
  output logic [1:0]              rsp_valid_o,
  input  logic [1:0]              rsp_ready_i,
  output logic [XLEN-1:0]         rsp_result_o,
  output logic                    rsp_cmp_o,
  output logic                    busy_o
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  state_e                  state_q, state_d;
  logic                    owner_q, owner_d, rr_q, rr_d, grant;
  logic [ALU_OP_WIDTH-1:0] op_q, op_d;
  logic [XLEN-1:0]         a_q, a_d, b_q, b_d, res_q, res_d;
  logic                    cmp_q, cmp_d;
  logic [1:0]              rv_q, rv_d;
  always_comb begin
    grant       = (&req_valid_i) ? ((PRIO_MODE != 0) ? 1'b0 : rr_q) : req_valid_i[1];
    req_ready_o = (state_q == IDLE && |req_valid_i) ? (grant ? 2'b10 : 2'b01) : 2'b00;
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    cmp_d       = cmp_q;
    rv_d        = rv_q;
    case (state_q)
      IDLE: if (|req_valid_i) begin
        op_d    = grant ? req1_operator_i : req0_operator_i;
        a_d     = grant ? req1_operand_a_i : req0_operand_a_i;
        b_d     = grant ? req1_operand_b_i : req0_operand_b_i;
        owner_d = grant;
        rr_d    = (PRIO_MODE != 0) ? rr_q : ~grant;
        state_d = EXEC;
      end
      EXEC: if (alu_ready_i) begin
        res_d   = alu_result_i;
        cmp_d   = alu_comparison_i;
        rv_d    = owner_q ? 2'b10 : 2'b01;
        state_d = RESP;
      end
      RESP: if (rsp_ready_i[owner_q]) begin
        rv_d    = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cmp_q   <= 1'b0;
      rv_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cmp_q   <= cmp_d;
      rv_q    <= rv_d;
    end
  end
  assign alu_operator_o  = op_q;
  assign alu_operand_a_o = a_q;
  assign alu_operand_b_o = b_q;
  assign alu_ex_ready_o  = (state_q == EXEC);
  assign rsp_valid_o     = rv_q;
  assign rsp_result_o    = res_q;
  assign rsp_cmp_o       = cmp_q;
  assign busy_o          = (state_q != IDLE);
endmodule

// File: tb/tb_riscv_alu_arbiter.sv
// tb_riscv_alu_arbiter: directed checks of arbitration, latency, hold, stall and reset behaviour.
module tb_riscv_alu_arbiter;
  localparam logic [6:0] OP_ADD  = 7'b0011000;
  localparam logic [6:0] OP_SLTU = 7'b0000011;
  logic        clk = 1'b0, rst = 1'b1;
  logic [1:0]  req_valid = 2'b00, rsp_ready = 2'b00;
  logic [6:0]  op0 = '0, op1 = '0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        alu_ready = 1'b1;
  logic [1:0]  req_ready, rsp_valid, p_req_ready, p_rsp_valid;
  logic [6:0]  alu_op, p_alu_op;
  logic [31:0] alu_a, alu_b, rsp_result, p_alu_a, p_alu_b, p_rsp_result;
  logic        ex_ready, rsp_cmp, busy, p_ex_ready, p_rsp_cmp, p_busy;
  logic [32:0] m, pm;
  int          pass_cnt = 0, total = 0;
  always #5 clk = ~clk;
  function automatic logic [32:0] alu_f(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    return (op == OP_SLTU) ? {a < b, 31'b0, a < b} : {a == b, a + b};
  endfunction
  assign m  = alu_f(alu_op, alu_a, alu_b);
  assign pm = alu_f(p_alu_op, p_alu_a, p_alu_b);
  riscv_alu_arbiter #(.XLEN(32), .ALU_OP_WIDTH(7), .PRIO_MODE(0)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req0_operator_i(op0), .req0_operand_a_i(a0), .req0_operand_b_i(b0),
    .req1_operator_i(op1), .req1_operand_a_i(a1), .req1_operand_b_i(b1),
    .alu_operator_o(alu_op), .alu_operand_a_o(alu_a), .alu_operand_b_o(alu_b),
    .alu_result_i(m[31:0]), .alu_comparison_i(m[32]), .alu_ready_i(alu_ready),
    .alu_ex_ready_o(ex_ready), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_cmp_o(rsp_cmp), .busy_o(busy));
  riscv_alu_arbiter #(.XLEN(32), .ALU_OP_WIDTH(7), .PRIO_MODE(1)) dut_p (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(p_req_ready),
    .req0_operator_i(op0), .req0_operand_a_i(a0), .req0_operand_b_i(b0),
    .req1_operator_i(op1), .req1_operand_a_i(a1), .req1_operand_b_i(b1),
    .alu_operator_o(p_alu_op), .alu_operand_a_o(p_alu_a), .alu_operand_b_o(p_alu_b),
    .alu_result_i(pm[31:0]), .alu_comparison_i(pm[32]), .alu_ready_i(alu_ready),
    .alu_ex_ready_o(p_ex_ready), .rsp_valid_o(p_rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(p_rsp_result), .rsp_cmp_o(p_rsp_cmp), .busy_o(p_busy));
  task automatic do_reset();
    req_valid = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_reset();
    #1;
    total++; if ({req_ready, rsp_valid, busy, ex_ready} !== 6'b0) $display("FAIL reset_ctl: got %b want 000000", {req_ready, rsp_valid, busy, ex_ready}); else pass_cnt++;
    total++; if ({alu_op, alu_a, alu_b, rsp_result, rsp_cmp} !== 104'b0) $display("FAIL reset_data: got %h want 0", {alu_op, alu_a, alu_b, rsp_result, rsp_cmp}); else pass_cnt++;
    do_reset();
  endtask
  task automatic test_single();
    op0 = OP_ADD; a0 = 32'd5; b0 = 32'd7; alu_ready = 1'b1; rsp_ready = 2'b01; req_valid = 2'b01;
    #1;
    total++; if (req_ready !== 2'b01) $display("FAIL single_rdy: got %b want 01", req_ready); else pass_cnt++;
    @(negedge clk);
    req_valid = 2'b00; a0 = 32'd99;
    total++; if ({busy, ex_ready, rsp_valid} !== 4'b1100) $display("FAIL single_exec: got %b want 1100", {busy, ex_ready, rsp_valid}); else pass_cnt++;
    total++; if ({alu_op, alu_a, alu_b} !== {OP_ADD, 32'd5, 32'd7}) $display("FAIL single_ops: got %h want %h", {alu_op, alu_a, alu_b}, {OP_ADD, 32'd5, 32'd7}); else pass_cnt++;
    @(negedge clk);
    total++; if ({busy, rsp_valid, rsp_result, rsp_cmp} !== {1'b1, 2'b01, 32'd12, 1'b0}) $display("FAIL single_rsp: got %h want %h", {busy, rsp_valid, rsp_result, rsp_cmp}, {1'b1, 2'b01, 32'd12, 1'b0}); else pass_cnt++;
    @(negedge clk);
    total++; if ({busy, rsp_valid} !== 3'b000) $display("FAIL single_done: got %b want 000", {busy, rsp_valid}); else pass_cnt++;
  endtask
  task automatic test_back_to_back();
    logic [1:0]  exp_rdy;
    logic [31:0] exp_res;
    do_reset();
    op0 = OP_ADD; a0 = 32'd1; b0 = 32'd1; op1 = OP_ADD; a1 = 32'd2; b1 = 32'd2;
    alu_ready = 1'b1; rsp_ready = 2'b11; req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_rdy = i[0] ? 2'b10 : 2'b01;
      exp_res = i[0] ? 32'd4 : 32'd2;
      #1;
      total++; if (req_ready !== exp_rdy) $display("FAIL rr_grant%0d: got %b want %b", i, req_ready, exp_rdy); else pass_cnt++;
      @(negedge clk);
      total++; if (alu_a !== exp_res / 2) $display("FAIL rr_opa%0d: got %0d want %0d", i, alu_a, exp_res / 2); else pass_cnt++;
      @(negedge clk);
      total++; if ({rsp_valid, rsp_result, rsp_cmp} !== {exp_rdy, exp_res, 1'b1}) $display("FAIL rr_rsp%0d: got %h want %h", i, {rsp_valid, rsp_result, rsp_cmp}, {exp_rdy, exp_res, 1'b1}); else pass_cnt++;
      @(negedge clk);
    end
    req_valid = 2'b00;
    @(negedge clk);
  endtask
  task automatic test_resp_hold();
    op1 = OP_SLTU; a1 = 32'd3; b1 = 32'hFFFF_FFFF; alu_ready = 1'b1; rsp_ready = 2'b00; req_valid = 2'b10;
    #1;
    total++; if (req_ready !== 2'b10) $display("FAIL hold_rdy: got %b want 10", req_ready); else pass_cnt++;
    @(negedge clk);
    req_valid = 2'b11; rsp_ready = 2'b01;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      total++; if ({rsp_valid, rsp_result, rsp_cmp, req_ready} !== {2'b10, 32'd1, 1'b1, 2'b00}) $display("FAIL hold%0d: got %h want %h", i, {rsp_valid, rsp_result, rsp_cmp, req_ready}, {2'b10, 32'd1, 1'b1, 2'b00}); else pass_cnt++;
      @(negedge clk);
    end
    req_valid = 2'b00; rsp_ready = 2'b10;
    @(negedge clk);
    total++; if ({busy, rsp_valid} !== 3'b000) $display("FAIL hold_idle: got %b want 000", {busy, rsp_valid}); else pass_cnt++;
  endtask
  task automatic test_stall();
    op0 = OP_ADD; a0 = 32'd10; b0 = 32'd20; alu_ready = 1'b0; rsp_ready = 2'b01; req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00; a0 = 32'hDEAD; b0 = 32'hBEEF;
    for (int i = 0; i < 3; i++) begin
      total++; if ({busy, ex_ready, rsp_valid, alu_a, alu_b} !== {1'b1, 1'b1, 2'b00, 32'd10, 32'd20}) $display("FAIL stall%0d: got %h want %h", i, {busy, ex_ready, rsp_valid, alu_a, alu_b}, {1'b1, 1'b1, 2'b00, 32'd10, 32'd20}); else pass_cnt++;
      @(negedge clk);
    end
    alu_ready = 1'b1;
    total++; if (rsp_valid !== 2'b00) $display("FAIL stall_early: got %b want 00", rsp_valid); else pass_cnt++;
    @(negedge clk);
    total++; if ({rsp_valid, rsp_result, ex_ready} !== {2'b01, 32'd30, 1'b0}) $display("FAIL stall_rsp: got %h want %h", {rsp_valid, rsp_result, ex_ready}, {2'b01, 32'd30, 1'b0}); else pass_cnt++;
    @(negedge clk);
  endtask
  task automatic test_reset_mid();
    op0 = OP_ADD; a0 = 32'd3; b0 = 32'd4; alu_ready = 1'b0; rsp_ready = 2'b11; req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    total++; if (busy !== 1'b1) $display("FAIL mid_exec: got %b want 1", busy); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total++; if ({busy, ex_ready, rsp_valid, req_ready, alu_op, alu_a, alu_b} !== 76'b0) $display("FAIL mid_async: got %h want 0", {busy, ex_ready, rsp_valid, req_ready, alu_op, alu_a, alu_b}); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0; alu_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++; if ({busy, rsp_valid, rsp_result} !== 35'b0) $display("FAIL mid_stale: got %h want 0", {busy, rsp_valid, rsp_result}); else pass_cnt++;
    req_valid = 2'b11;
    #1;
    total++; if (req_ready !== 2'b01) $display("FAIL mid_rrptr: got %b want 01", req_ready); else pass_cnt++;
    req_valid = 2'b00;
    @(negedge clk);
  endtask
  task automatic test_prio();
    int grants0 = 0, grants1 = 0;
    do_reset();
    op0 = OP_ADD; op1 = OP_ADD; alu_ready = 1'b1; rsp_ready = 2'b11; req_valid = 2'b11;
    for (int i = 0; i < 9; i++) begin
      #1;
      if (p_req_ready == 2'b01) grants0++;
      if (p_req_ready == 2'b10) grants1++;
      @(negedge clk);
    end
    total++; if (grants0 !== 3 || grants1 !== 0) $display("FAIL prio_grants: got %0d/%0d want 3/0", grants0, grants1); else pass_cnt++;
    req_valid = 2'b10;
    #1;
    total++; if (p_req_ready !== 2'b10) $display("FAIL prio_port1: got %b want 10", p_req_ready); else pass_cnt++;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    total++; if (p_rsp_valid !== 2'b10) $display("FAIL prio_rsp1: got %b want 10", p_rsp_valid); else pass_cnt++;
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_resp_hold();
    test_stall();
    test_reset_mid();
    test_prio();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/riscv_alu_arbiter.md
Name: riscv_alu_arbiter

Overview:
- Shares one riscv_alu instance between two requesters: port 0, the execute-stage issue path, and port 1, a secondary path such as branch/address compare or debug.
- Arbitrates, registers the chosen operation and drives it into the ALU.
- Waits on the ALU ready, captures result and comparison flag, then holds a response until the owning requester accepts it.
- Sits between the decode/execute control and the ALU; only one operation is in flight at a time.

Parameters:
- XLEN, 32, datapath width; must match the ALU.
- ALU_OP_WIDTH, 7, operator field width; must match riscv_defines.
- PRIO_MODE, 0, 0 = round-robin between ports; 1 = fixed priority, port 0 always wins.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid_i  input  2  per-port request valid; bit k belongs to port k.
- req_ready_o  output  2  per-port request accept; at most one bit high.
- req0_operator_i / req1_operator_i  input  ALU_OP_WIDTH  requested ALU operation.
- req0_operand_a_i / req1_operand_a_i  input  XLEN  operand A.
- req0_operand_b_i / req1_operand_b_i  input  XLEN  operand B.
- alu_operator_o  output  ALU_OP_WIDTH  registered operator to the ALU.
- alu_operand_a_o  output  XLEN  registered operand A to the ALU.
- alu_operand_b_o  output  XLEN  registered operand B to the ALU.
- alu_result_i  input  XLEN  ALU result.
- alu_comparison_i  input  1  ALU comparison result.
- alu_ready_i  input  1  ALU result valid this cycle.
- alu_ex_ready_o  output  1  high in EXEC; drives the ALU ex_ready_i.
- rsp_valid_o  output  2  per-port response valid; at most one bit high.
- rsp_ready_i  input  2  per-port response accept.
- rsp_result_o  output  XLEN  shared response data.
- rsp_cmp_o  output  1  shared captured comparison flag.
- busy_o  output  1  high whenever the state is not IDLE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: state = IDLE, owner = 0, rr_ptr = 0, alu_operator_o/alu_operand_a_o/alu_operand_b_o = 0, rsp_valid_o = 0, rsp_result_o = 0, rsp_cmp_o = 0, busy_o = 0, req_ready_o = 0, alu_ex_ready_o = 0.
- Three states: IDLE, EXEC, RESP.

IDLE:
- Grant is combinational from req_valid_i:
  - Only one port valid: grant it.
  - Both valid, PRIO_MODE=0: grant port rr_ptr.
  - Both valid, PRIO_MODE=1: grant port 0.
- req_ready_o[grant] = 1 only in IDLE with that port valid; otherwise req_ready_o = 0.
- On the handshake:
  - Register the granted port's operator and operands into the alu_* outputs.
  - Set owner = grant.
  - Set rr_ptr = ~grant (round-robin mode only; rr_ptr frozen when PRIO_MODE=1).
  - Next state = EXEC.
- No valid: stay in IDLE; the alu_* registers hold their last values.

EXEC:
- alu_* outputs stay stable and alu_ex_ready_o = 1.
- alu_ready_i = 1: capture alu_result_i into rsp_result_o and alu_comparison_i into rsp_cmp_o, set rsp_valid_o[owner] = 1, next state = RESP.
- alu_ready_i = 0: remain in EXEC indefinitely; no timeout.

RESP:
- rsp_valid_o[owner], rsp_result_o and rsp_cmp_o are held stable.
- rsp_ready_i[owner] = 1: rsp_valid_o clears next cycle and next state = IDLE.
- rsp_ready_i on the non-owner port is ignored.
- No new request is accepted in RESP; accept resumes in IDLE the following cycle.

Latency and throughput:
- Request handshake at edge N puts the operands on the ALU in cycle N+1.
- With alu_ready_i = 1, rsp_valid_o is high in cycle N+2.
- Sustained throughput is one operation per 3 cycles with immediate rsp_ready.

Boundary rules:
- A requester that drops req_valid_i before its ready bit is not served and nothing is latched.
- Operand values are sampled only on the handshake edge.
- Reset in EXEC or RESP abandons the operation: no response is issued and all outputs return to reset values asynchronously.
- Response data is exactly the ALU output width; no re-extension or masking is applied.
- PRIO_MODE=1 allows port 1 to starve under continuous port-0 requests; this is intended.

Test Plan:
- Port 0 only, ADD with A=5, B=7, alu_ready_i tied 1 -> rsp_valid_o=2'b01 two cycles after the handshake, rsp_result_o=12, rsp_cmp_o follows the ALU, busy_o high for 2 cycles.
- Both ports valid continuously after reset, PRIO_MODE=0, rsp_ready_i=2'b11 -> grants in order 0,1,0,1; a new grant every 3 cycles; each response is routed to the correct rsp_valid_o bit.
- Port 1 SLTU with A=3, B=0xFFFF_FFFF, rsp_ready_i[1] held 0 for 4 cycles -> rsp_result_o=1 and rsp_cmp_o=1 stable for those cycles, req_ready_o=0 throughout, IDLE one cycle after accept.
- alu_ready_i held 0 for 3 cycles in EXEC -> state stays EXEC, alu_* operands unchanged, alu_ex_ready_o=1, response appears the cycle after alu_ready_i rises.
- rst asserted mid-EXEC -> all outputs return to 0 without waiting for a clock edge; after release, no stale response and rr_ptr=0.
- PRIO_MODE=1 with both ports valid for 9 cycles -> only port 0 granted (3 times); port 1 granted on the first IDLE cycle after req_valid_i[0] drops.
